// File: rtl/pc_register_unit_if.sv
// Fetch-side bundle between the PC register, the next-PC mux/hazard logic and
// instruction memory. The master side is the PC register: it drives the fetch
// address and status, and receives the control and target inputs.
interface pc_register_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] pc_target;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        trap;

    modport master (
        input  stall, redirect, pc_target, fetch_ready,
        output pc, pc_plus4, fetch_valid, trap
    );

    modport slave (
        output stall, redirect, pc_target, fetch_ready,
        input  pc, pc_plus4, fetch_valid, trap
    );
endinterface

// File: rtl/pc_register_unit.sv
// Program-counter register. Holds the fetch address, advances on an accepted
// fetch, keeps the most recent redirect seen while not advancing, and locks
// into a trap state when a misaligned address is about to be loaded.
//
// state | meaning
// BOOT  | out of reset, no fetch issued yet; first edge moves to RUN
// RUN   | fetch request valid; pc advances when fetch_ready & ~stall
// TRAP  | misaligned target accepted; pc frozen until reset
module pc_register_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] INCR       = 32'd4
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_register_unit_if.master  pc_if
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pend_valid_nxt;
    logic [31:0] w_pend_target_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_sel_addr;
    logic        w_advance;
    logic        w_misaligned;

    // Sequential increment wraps modulo 2^32; carry is dropped.
    assign w_pc_plus4 = r_pc + INCR;

    // Redirect beats a held redirect, which beats the sequential address.
    assign w_sel_addr   = pc_if.redirect   ? pc_if.pc_target :
                          r_pend_valid     ? r_pend_target   :
                                             w_pc_plus4;
    assign w_misaligned = (w_sel_addr[1:0] != 2'b00);
    assign w_advance    = (r_state == RUN) && pc_if.fetch_ready && !pc_if.stall;

    // State, pc and held-redirect registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_ADDR;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0000_0000;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    // Next-state and next-pc selection; a misaligned pick traps instead of loading.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;

        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                if (pc_if.redirect) begin
                    w_pend_valid_nxt  = 1'b1;
                    w_pend_target_nxt = pc_if.pc_target;
                end
            end
            RUN: begin
                if (w_advance) begin
                    w_pend_valid_nxt = 1'b0;
                    if (w_misaligned) begin
                        w_state_nxt = TRAP;
                    end else begin
                        w_pc_nxt = w_sel_addr;
                    end
                end else if (pc_if.redirect) begin
                    w_pend_valid_nxt  = 1'b1;
                    w_pend_target_nxt = pc_if.pc_target;
                end
            end
            TRAP: begin
                w_state_nxt = TRAP;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign pc_if.pc          = r_pc;
    assign pc_if.pc_plus4    = w_pc_plus4;
    assign pc_if.fetch_valid = (r_state == RUN);
    assign pc_if.trap        = (r_state == TRAP);

endmodule

// File: tb/tb_pc_register_unit.sv
// Bench for pc_register_unit: each cycle's stimulus is driven together with the
// outcome expected after the next rising edge; the expectation is queued and
// popped for comparison once that edge has passed.
module tb_pc_register_unit;

    logic clk;
    logic rst_n;

    pc_register_unit_if u_if ();

    pc_register_unit #(
        .RESET_ADDR (32'h0000_0000),
        .INCR       (32'd4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_if (u_if)
    );

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        trap;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the outputs against an explicit expectation at the current time.
    task automatic chk_now(input string tag, input logic [31:0] pc, input logic fv, input logic trap);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        chk({tag, ".pc"},    u_if.pc,          pc);
        chk({tag, ".pc4"},   u_if.pc_plus4,    p4);
        chk({tag, ".fv"},    {31'd0, u_if.fetch_valid}, {31'd0, fv});
        chk({tag, ".trap"},  {31'd0, u_if.trap},        {31'd0, trap});
    endtask

    // Drive one cycle of inputs, queue the expected result, clock, then compare.
    task automatic step(input string tag, input logic st, input logic rd,
                        input logic [31:0] tgt, input logic rdy,
                        input logic [31:0] e_pc, input logic e_fv, input logic e_trap);
        exp_t e;
        u_if.stall       = st;
        u_if.redirect    = rd;
        u_if.pc_target   = tgt;
        u_if.fetch_ready = rdy;
        e.pc   = e_pc;
        e.fv   = e_fv;
        e.trap = e_trap;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
        end else begin
            e = sb_q.pop_front();
            chk_now(tag, e.pc, e.fv, e.trap);
        end
    endtask

    // Pulse reset asynchronously between edges and check it acts before the next edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_now(tag, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        u_if.stall       = 1'b0;
        u_if.redirect    = 1'b0;
        u_if.pc_target   = 32'h0;
        u_if.fetch_ready = 1'b0;
        #12;
        chk_now("reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_now("boot", 32'h0, 1'b0, 1'b0);

        // Sequential run
        step("run0", 0, 0, 32'h0, 1, 32'h0, 1, 0);
        step("run1", 0, 0, 32'h0, 1, 32'h4, 1, 0);
        step("run2", 0, 0, 32'h0, 1, 32'h8, 1, 0);

        // Redirect arriving during a stall is held and taken on release
        step("stl0", 1, 1, 32'h40, 1, 32'h8, 1, 0);
        step("stl1", 1, 0, 32'h0,  1, 32'h8, 1, 0);
        step("stl2", 1, 0, 32'h0,  1, 32'h8, 1, 0);
        step("rel",  0, 0, 32'h0,  1, 32'h40, 1, 0);
        step("seq",  0, 0, 32'h0,  1, 32'h44, 1, 0);

        // Latest held redirect wins
        step("lw0",  1, 1, 32'h100, 1, 32'h44, 1, 0);
        step("lw1",  1, 1, 32'h200, 1, 32'h44, 1, 0);
        step("lw2",  0, 0, 32'h0,   1, 32'h200, 1, 0);
        step("lw3",  0, 0, 32'h0,   1, 32'h204, 1, 0);

        // Live redirect at release beats the held one; held one is then dropped
        step("lv0",  1, 1, 32'h100, 1, 32'h204, 1, 0);
        step("lv1",  0, 1, 32'h300, 1, 32'h300, 1, 0);
        step("lv2",  0, 0, 32'h0,   1, 32'h304, 1, 0);

        // fetch_ready low holds pc with fetch_valid kept high, and latches redirects
        step("fr0",  0, 0, 32'h0,   0, 32'h304, 1, 0);
        step("fr1",  0, 1, 32'h500, 0, 32'h304, 1, 0);
        step("fr2",  1, 0, 32'h0,   0, 32'h304, 1, 0);
        step("fr3",  0, 0, 32'h0,   1, 32'h500, 1, 0);

        // Address wrap
        step("wr0",  0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0);
        step("wr1",  0, 0, 32'h0, 1, 32'h0, 1, 0);
        step("wr2",  0, 0, 32'h0, 1, 32'h4, 1, 0);

        // Mid-run async reset with a held redirect that must be discarded
        step("mr0",  0, 1, 32'h20, 1, 32'h20, 1, 0);
        step("mr1",  1, 1, 32'h80, 1, 32'h20, 1, 0);
        async_reset("arst");
        step("mr2",  0, 0, 32'h0, 1, 32'h0, 1, 0);
        step("mr3",  0, 0, 32'h0, 1, 32'h4, 1, 0);

        // Misaligned live redirect traps; trap is sticky until reset
        step("tp0",  0, 1, 32'h42, 1, 32'h4, 0, 1);
        step("tp1",  0, 1, 32'h10, 1, 32'h4, 0, 1);
        step("tp2",  0, 0, 32'h0,  1, 32'h4, 0, 1);
        async_reset("trst");

        // Redirect seen in BOOT is used by the first advance
        step("bt0",  0, 1, 32'h40, 1, 32'h0,  1, 0);
        step("bt1",  0, 0, 32'h0,  1, 32'h40, 1, 0);

        // Misaligned held redirect is checked when consumed, not when latched
        step("pm0",  1, 1, 32'h43, 1, 32'h40, 1, 0);
        step("pm1",  0, 0, 32'h0,  1, 32'h40, 0, 1);
        step("pm2",  0, 0, 32'h0,  1, 32'h40, 0, 1);

        if (sb_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
